// File: rtl/serial_divider_pkg.sv
// Shared widths, FSM state type and iteration-counter sizing for the serial
// restoring divider.
package serial_divider_pkg;

  localparam int DEF_DIVIDEND_W = 16;
  localparam int DEF_DIVISOR_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter that walks DIVIDEND_W-1 down to 0.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEF_DIVIDEND_W);

endpackage

// File: rtl/serial_divider_if.sv
// Start/busy/done handshake plus operand and result buses of the serial divider.
interface serial_divider_if #(
  parameter int DIVIDEND_W = serial_divider_pkg::DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = serial_divider_pkg::DEF_DIVISOR_W
);

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/serial_divider_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the
// divisor, keep the difference only when it does not go negative.
module divide_step #(
  parameter int DIVISOR_W = serial_divider_pkg::DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W-1:0] part_rem,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] part_rem_next,
  output logic                 quot_bit
);

  logic [DIVISOR_W:0] trial;
  logic [DIVISOR_W:0] div_ext;

  // The partial remainder is always below the divisor, so its extra top bit is
  // zero and only the low DIVISOR_W bits are carried between iterations; the
  // trial value keeps the full DIVISOR_W+1 bits for the compare.
  always_comb begin
    // NOTE: every output gets a default before the branch, so no path leaves
    // a value unassigned and no latch is inferred.
    trial         = {part_rem, bit_in};
    div_ext       = {1'b0, divisor};
    part_rem_next = trial[DIVISOR_W-1:0];
    quot_bit      = 1'b0;
    if (trial >= div_ext) begin
      part_rem_next = DIVISOR_W'(trial - div_ext);
      quot_bit      = 1'b1;
    end
  end

endmodule

// File: rtl/serial_divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock, with a
// start/busy/done handshake and a one-cycle divide-by-zero shortcut.
module serial_divider
  import serial_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input logic             clk,
  input logic             rst,
  serial_divider_if.slave bus
);

  localparam int ITER_W = cnt_width(DIVIDEND_W);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DIVIDEND_W - 1);

  state_e                state;
  logic [ITER_W-1:0]     iter_cnt;
  logic [DIVIDEND_W-1:0] work_q;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [DIVISOR_W-1:0]  part_rem;
  logic                  busy_q;
  logic                  done_q;
  logic                  dbz_q;
  logic [DIVIDEND_W-1:0] quot_q;
  logic [DIVISOR_W-1:0]  rem_q;

  logic [DIVISOR_W-1:0]  part_rem_next;
  logic                  quot_bit;
  logic [DIVIDEND_W-1:0] work_next;

  // work_q shifts the dividend out of its MSB while quotient bits enter at the
  // LSB; after DIVIDEND_W shifts it holds the complete quotient.
  divide_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .part_rem      (part_rem),
    .bit_in        (work_q[DIVIDEND_W-1]),
    .divisor       (divisor_q),
    .part_rem_next (part_rem_next),
    .quot_bit      (quot_bit)
  );

  assign work_next = {work_q[DIVIDEND_W-2:0], quot_bit};

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are plain flops, not a memory, so they are
      // reset along with the control state at no real cost.
      state     <= IDLE;
      iter_cnt  <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      part_rem  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            if (bus.divisor == '0) begin
              // No iterations needed: publish the fixed result immediately.
              state  <= DONE;
              done_q <= 1'b1;
              dbz_q  <= 1'b1;
              quot_q <= '1;
              rem_q  <= bus.dividend[DIVISOR_W-1:0];
            end else begin
              state     <= RUN;
              busy_q    <= 1'b1;
              dbz_q     <= 1'b0;
              work_q    <= bus.dividend;
              divisor_q <= bus.divisor;
              part_rem  <= '0;
              iter_cnt  <= LAST_ITER;
            end
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          part_rem <= part_rem_next;
          work_q   <= work_next;
          if (iter_cnt == '0) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            quot_q <= work_next;
            rem_q  <= part_rem_next;
          end else begin
            iter_cnt <= iter_cnt - 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_serial_divider.sv
// Self-checking bench for serial_divider: directed table, hand-written
// back-to-back and reset sequences, then random operands against a model.
module tb_serial_divider;
  import serial_divider_pkg::*;

  localparam int DW       = DEF_DIVIDEND_W;
  localparam int VW       = DEF_DIVISOR_W;
  localparam int MAX_WAIT = 40;
  localparam int N_RAND   = 150;

  typedef struct {
    string         name;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    int            lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  serial_divider_if bus ();

  serial_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division; divisor 0 yields all-ones quotient,
  // low dividend byte as remainder, flag set, done right after accept.
  function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                output logic [DW-1:0] q, output logic [VW-1:0] r,
                                output logic z, output int lat);
    logic [DW-1:0] rem_full;
    if (b == '0) begin
      q   = '1;
      r   = a[VW-1:0];
      z   = 1'b1;
      lat = 0;
    end else begin
      q        = a / DW'(b);
      rem_full = a % DW'(b);
      r        = rem_full[VW-1:0];
      z        = 1'b0;
      lat      = DW;
    end
  endfunction

  // Pulses start for one cycle, then samples on falling edges. lat counts the
  // rising edges from the accept edge to the one that raised done; busy_cnt
  // counts the sampled cycles with busy high. Returns at the done sample.
  task automatic run_op(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                        output int lat, output int busy_cnt, output logic seen);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(negedge clk);
    bus.start = 1'b0;
    lat       = 0;
    busy_cnt  = 0;
    seen      = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t          vecs[6];
  int            lat;
  int            busy_cnt;
  logic          seen;
  logic [DW-1:0] m_q;
  logic [VW-1:0] m_r;
  logic          m_z;
  int            m_lat;
  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_dvs;
  int            done_cnt;

  initial begin
    vecs[0] = '{"100_7",     16'd100,   8'd7,   16'd14,    8'd2,   1'b0, 16};
    vecs[1] = '{"65535_255", 16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 16};
    vecs[2] = '{"65535_1",   16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 16};
    vecs[3] = '{"5_9",       16'd5,     8'd9,   16'd0,     8'd5,   1'b0, 16};
    vecs[4] = '{"1234_0",    16'd1234,  8'd0,   16'hFFFF,  8'hD2,  1'b1, 0};
    vecs[5] = '{"10_3",      16'd10,    8'd3,   16'd3,     8'd1,   1'b0, 16};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(negedge clk);
    check("reset/busy", bus.busy, 0);
    check("reset/done", bus.done, 0);
    check("reset/quotient", bus.quotient, 0);
    check("reset/remainder", bus.remainder, 0);
    check("reset/div_by_zero", bus.div_by_zero, 0);
    rst = 1'b0;

    // Directed table: results, latency, busy length, single-cycle done, hold.
    foreach (vecs[i]) begin
      run_op(vecs[i].dvd, vecs[i].dvs, lat, busy_cnt, seen);
      check({vecs[i].name, "/done_seen"}, seen, 1);
      check({vecs[i].name, "/quotient"}, bus.quotient, vecs[i].q);
      check({vecs[i].name, "/remainder"}, bus.remainder, vecs[i].r);
      check({vecs[i].name, "/div_by_zero"}, bus.div_by_zero, vecs[i].dbz);
      check({vecs[i].name, "/latency"}, lat, vecs[i].lat);
      check({vecs[i].name, "/busy_cycles"}, busy_cnt, vecs[i].lat);
      @(negedge clk);
      check({vecs[i].name, "/done_pulse"}, bus.done, 0);
      check({vecs[i].name, "/quotient_hold"}, bus.quotient, vecs[i].q);
    end

    // Back-to-back: start held high throughout; junk operands while busy must
    // be ignored, and 999/8 presented in the DONE cycle is accepted there.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd10;
    @(negedge clk);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      bus.dividend = (i < 10) ? 16'($urandom) : 16'd999;
      bus.divisor  = (i < 10) ? 8'($urandom)  : 8'd8;
      @(negedge clk);
      lat++;
    end
    check("b2b_first/done_seen", seen, 1);
    check("b2b_first/latency", lat, 16);
    check("b2b_first/quotient", bus.quotient, 16'd100);
    check("b2b_first/remainder", bus.remainder, 8'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b/no_gap_busy", bus.busy, 1);
    check("b2b/done_dropped", bus.done, 0);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    check("b2b_second/done_seen", seen, 1);
    check("b2b_second/latency", lat, 16);
    check("b2b_second/quotient", bus.quotient, 16'd124);
    check("b2b_second/remainder", bus.remainder, 8'd7);

    // Reset five cycles into 300/7, with a start asserted alongside rst.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'd300;
    bus.divisor  = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 16'd50;
    bus.divisor  = 8'd5;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    check("midreset/busy", bus.busy, 0);
    check("midreset/done", bus.done, 0);
    check("midreset/quotient", bus.quotient, 0);
    check("midreset/remainder", bus.remainder, 0);
    check("midreset/div_by_zero", bus.div_by_zero, 0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_cnt++;
    end
    check("midreset/no_activity", done_cnt, 0);
    run_op(16'd300, 8'd7, lat, busy_cnt, seen);
    check("after_reset/done_seen", seen, 1);
    check("after_reset/latency", lat, 16);
    check("after_reset/quotient", bus.quotient, 16'd42);
    check("after_reset/remainder", bus.remainder, 8'd6);

    // Random operands against the arithmetic model.
    for (int n = 0; n < N_RAND; n++) begin
      r_dvd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) r_dvd = 16'($urandom_range(0, 300));
      r_dvs = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      model(r_dvd, r_dvs, m_q, m_r, m_z, m_lat);
      run_op(r_dvd, r_dvs, lat, busy_cnt, seen);
      check("rand/done_seen", seen, 1);
      check("rand/quotient", bus.quotient, m_q);
      check("rand/remainder", bus.remainder, m_r);
      check("rand/div_by_zero", bus.div_by_zero, m_z);
      check("rand/latency", lat, m_lat);
      check("rand/busy_cycles", busy_cnt, m_lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
